// File: rtl/fa_chk_pkg.sv
// ----------------------------------------------------------------------------
// fa_chk_pkg
// Shared definitions for the full-adder response checker: FSM state encoding,
// vector-space constants and the golden full-adder functions.
// No ports (package).
// ----------------------------------------------------------------------------
package fa_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int         NUM_VEC  = 8;
    localparam logic [2:0] LAST_VEC = 3'(NUM_VEC - 1);

    // vec is {a, b, c_in}
    function automatic logic exp_sum(input logic [2:0] vec);
        return vec[2] ^ vec[1] ^ vec[0];
    endfunction

    function automatic logic exp_cout(input logic [2:0] vec);
        return (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
    endfunction

endpackage

// File: rtl/fa_golden.sv
// ----------------------------------------------------------------------------
// fa_golden
// Combinational reference full adder.
// Ports:
//   vec      in  3  {a, b, c_in}
//   exp_sum  out 1  expected sum
//   exp_cout out 1  expected carry out
// ----------------------------------------------------------------------------
module fa_golden (
    input  logic [2:0] vec,
    output logic       exp_sum,
    output logic       exp_cout
);

    // Package functions are scope-qualified because the port names match them.
    assign exp_sum  = fa_chk_pkg::exp_sum(vec);
    assign exp_cout = fa_chk_pkg::exp_cout(vec);

endmodule

// File: rtl/fa_resp_checker.sv
// ----------------------------------------------------------------------------
// fa_resp_checker
// Drives all 8 {a,b,c_in} vectors into an external 1-bit full adder in
// ascending order, samples its sum/c_out after a settle delay, compares them
// to a golden model and records mismatch count and first failing vector.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             level-sampled run request (honoured in IDLE or DONE)
//   a, b, c_in        operands driven to the adder under test
//   sum, c_out        adder under test outputs
//   busy, done, pass  run status (pass valid while done)
//   err_count         saturating mismatch counter for this run
//   first_err_valid   a mismatch has been recorded this run
//   first_err_vec     {a,b,c_in} of the first mismatching vector
// Handshake: start has no acknowledge; it is sampled on every rising edge and
// only acted on in IDLE or DONE, so holding it high simply re-launches a run
// one cycle after each DONE.
// ----------------------------------------------------------------------------
module fa_resp_checker
    import fa_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c_in,
    input  logic             sum,
    input  logic             c_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [2:0]       first_err_vec
);

    localparam logic [3:0] WAIT_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] vec;
    logic [3:0] wait_cnt;
    logic       gold_sum;
    logic       gold_cout;
    logic       mismatch;
    logic       launch;

    fa_golden u_golden (
        .vec      (vec),
        .exp_sum  (gold_sum),
        .exp_cout (gold_cout)
    );

    // Case inequality so an X/Z from the adder under test counts as a miss.
    assign mismatch = (sum !== gold_sum) || (c_out !== gold_cout);
    assign launch   = start && ((state == ST_IDLE) || (state == ST_DONE));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_DRIVE;
            ST_DRIVE: state_nxt = (SETTLE_CYCLES > 0) ? ST_WAIT : ST_CHECK;
            ST_WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = (vec == LAST_VEC) ? ST_DONE : ST_DRIVE;
            ST_DONE:  if (start) state_nxt = ST_DRIVE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == ST_DRIVE) || (state == ST_WAIT) || (state == ST_CHECK);
        done = (state == ST_DONE);
        pass = done && (err_count == '0);
    end

    // Vector, settle counter, operand and error bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec             <= 3'd0;
            wait_cnt        <= 4'd0;
            a               <= 1'b0;
            b               <= 1'b0;
            c_in            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 3'd0;
        end else if (launch) begin
            vec             <= 3'd0;
            wait_cnt        <= 4'd0;
            a               <= 1'b0;
            b               <= 1'b0;
            c_in            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 3'd0;
        end else begin
            case (state)
                ST_DRIVE: begin
                    {a, b, c_in} <= vec;
                    wait_cnt     <= 4'd0;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= vec;
                        end
                    end
                    // vec stays at LAST_VEC in DONE; it never wraps inside a run.
                    if (vec != LAST_VEC) vec <= vec + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fa_resp_checker.sv
// ----------------------------------------------------------------------------
// tb_fa_resp_checker
// Directed bench: five checker instances with different settle/width settings
// each drive a behavioural adder (correct, sum stuck-at-0, or c_out inverted).
// ----------------------------------------------------------------------------
module tb_fa_resp_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mode_stk = 1;

    always #5 clk = ~clk;

    // Behavioural adder: mode 0 correct, 1 sum stuck-at-0, 2 c_out inverted.
    function automatic logic [1:0] adder(input logic x, input logic y, input logic z, input int mode);
        logic [1:0] t;
        t = {1'b0, x} + {1'b0, y} + {1'b0, z};
        if (mode == 1) t[0] = 1'b0;
        if (mode == 2) t[1] = ~t[1];
        return t;
    endfunction

    // u_s1: SETTLE=1, correct adder
    logic a1, b1, c1, sum1, cout1, busy1, done1, pass1, fev1v;
    logic [3:0] err1;
    logic [2:0] fev1;
    assign {cout1, sum1} = adder(a1, b1, c1, 0);
    fa_resp_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a1), .b(b1), .c_in(c1),
        .sum(sum1), .c_out(cout1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_valid(fev1v), .first_err_vec(fev1));

    // u_stk: SETTLE=1, sum stuck-at-0 (switchable)
    logic ak, bk, ck, sumk, coutk, busyk, donek, passk, fevkv;
    logic [3:0] errk;
    logic [2:0] fevk;
    assign {coutk, sumk} = adder(ak, bk, ck, mode_stk);
    fa_resp_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) u_stk (
        .clk(clk), .rst_n(rst_n), .start(start), .a(ak), .b(bk), .c_in(ck),
        .sum(sumk), .c_out(coutk), .busy(busyk), .done(donek), .pass(passk),
        .err_count(errk), .first_err_valid(fevkv), .first_err_vec(fevk));

    // u_inv: SETTLE=1, ERR_W=2, c_out inverted
    logic ai, bi, ci, sumi, couti, busyi, donei, passi, feviv;
    logic [1:0] erri;
    logic [2:0] fevi;
    assign {couti, sumi} = adder(ai, bi, ci, 2);
    fa_resp_checker #(.SETTLE_CYCLES(1), .ERR_W(2)) u_inv (
        .clk(clk), .rst_n(rst_n), .start(start), .a(ai), .b(bi), .c_in(ci),
        .sum(sumi), .c_out(couti), .busy(busyi), .done(donei), .pass(passi),
        .err_count(erri), .first_err_valid(feviv), .first_err_vec(fevi));

    // u_s0: SETTLE=0, correct adder
    logic a0, b0, c0, sum0, cout0, busy0, done0, pass0, fev0v;
    logic [3:0] err0;
    logic [2:0] fev0;
    assign {cout0, sum0} = adder(a0, b0, c0, 0);
    fa_resp_checker #(.SETTLE_CYCLES(0), .ERR_W(4)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a0), .b(b0), .c_in(c0),
        .sum(sum0), .c_out(cout0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_err_valid(fev0v), .first_err_vec(fev0));

    // u_s3: SETTLE=3, correct adder
    logic a3, b3, c3, sum3, cout3, busy3, done3, pass3, fev3v;
    logic [3:0] err3;
    logic [2:0] fev3;
    assign {cout3, sum3} = adder(a3, b3, c3, 0);
    fa_resp_checker #(.SETTLE_CYCLES(3), .ERR_W(4)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a3), .b(b3), .c_in(c3),
        .sum(sum3), .c_out(cout3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_err_valid(fev3v), .first_err_vec(fev3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_s1_reset(input string tag);
        check({tag, "_busy"}, 32'(busy1), 0);
        check({tag, "_done"}, 32'(done1), 0);
        check({tag, "_pass"}, 32'(pass1), 0);
        check({tag, "_err"},  32'(err1), 0);
        check({tag, "_fevv"}, 32'(fev1v), 0);
        check({tag, "_fev"},  32'(fev1), 0);
        check({tag, "_abc"},  32'({a1, b1, c1}), 0);
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        start = 1'b0;
        mode_stk = 1;
        tick();
        tick();
        check_s1_reset("rst");
        check("rst_s3_done", 32'(done3), 0);
        rst_n = 1'b1;
        tick();

        // Run 1: all instances launched from the same edge
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r1_busy_e0", 32'(busy1), 1);
        for (int e = 1; e <= 40; e++) begin
            tick();
            if ((e % 3 == 1) && (e <= 22)) check("r1_s1_vec", 32'({a1, b1, c1}), 32'((e - 1) / 3));
            if (e == 23) check("r1_s1_busy_e23", 32'(busy1), 1);
            if (e == 23 || e == 24) check("r1_s1_done", 32'(done1), 32'(e == 24));
            if (e == 15 || e == 16) check("r1_s0_done", 32'(done0), 32'(e == 16));
            if (e == 39 || e == 40) check("r1_s3_done", 32'(done3), 32'(e == 40));
        end
        check("r1_s1_pass", 32'(pass1), 1);
        check("r1_s1_err",  32'(err1), 0);
        check("r1_s1_fevv", 32'(fev1v), 0);
        check("r1_s1_abc_hold", 32'({a1, b1, c1}), 7);
        check("r1_stk_done", 32'(donek), 1);
        check("r1_stk_pass", 32'(passk), 0);
        check("r1_stk_err",  32'(errk), 4);
        check("r1_stk_fevv", 32'(fevkv), 1);
        check("r1_stk_fev",  32'(fevk), 1);
        check("r1_inv_done", 32'(donei), 1);
        check("r1_inv_pass", 32'(passi), 0);
        check("r1_inv_err",  32'(erri), 3);
        check("r1_inv_fevv", 32'(feviv), 1);
        check("r1_inv_fev",  32'(fevi), 0);
        check("r1_s0_pass",  32'(pass0), 1);
        check("r1_s3_pass",  32'(pass3), 1);

        // Run 2: restart from DONE after a failing run; start toggled while busy
        mode_stk = 0;
        start = 1'b1;
        tick();
        check("r2_stk_err_clr",  32'(errk), 0);
        check("r2_stk_fevv_clr", 32'(fevkv), 0);
        check("r2_stk_fev_clr",  32'(fevk), 0);
        check("r2_stk_done_drop", 32'(donek), 0);
        check("r2_s1_busy", 32'(busy1), 1);
        for (int e = 1; e <= 24; e++) begin
            start = (e < 20) ? 1'(e % 2) : 1'b0;
            tick();
            if (e == 23 || e == 24) check("r2_s1_done", 32'(done1), 32'(e == 24));
        end
        check("r2_s1_pass", 32'(pass1), 1);
        check("r2_s1_abc",  32'({a1, b1, c1}), 7);
        check("r2_stk_done", 32'(donek), 1);
        check("r2_stk_pass", 32'(passk), 1);
        check("r2_stk_err",  32'(errk), 0);

        // Run 3: reset mid-run while vector 4 is applied
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 13; e++) tick();
        check("r3_s1_vec4", 32'({a1, b1, c1}), 4);
        check("r3_s1_busy", 32'(busy1), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_s1_reset("r3_midrst");

        // Run 4: fresh run with start held high; auto-restart after DONE
        start = 1'b1;
        tick();
        for (int e = 1; e <= 25; e++) begin
            tick();
            if (e == 24) check("r4_s1_done", 32'(done1), 1);
            if (e == 24) check("r4_s1_pass", 32'(pass1), 1);
            if (e == 25) check("r4_s1_done_drop", 32'(done1), 0);
            if (e == 25) check("r4_s1_busy_again", 32'(busy1), 1);
        end
        start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
